// File: rtl/nvdla_cmac_op_seq.sv
// nvdla_cmac_op_seq: per-layer CMAC sequencer that latches config, admits beats, drains the MAC pipe and pulses done.
module nvdla_cmac_op_seq #(
    parameter int CNT_W    = 24,
    parameter int PIPE_LAT = 7,
    parameter int WARMUP   = 2
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             reg2dp_op_en,
    input  logic [1:0]       reg2dp_proc_precision,
    input  logic             reg2dp_conv_mode,
    input  logic [CNT_W-1:0] reg2dp_atomic_total,
    input  logic             sc2mac_dat_valid,
    input  logic             sc2mac_dat_layer_end,
    output logic             mac_in_rdy,
    output logic             cfg_is_int8,
    output logic             cfg_is_int16,
    output logic             cfg_is_fp16,
    output logic             cfg_is_wg,
    output logic             slcg_en,
    output logic             op_busy,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             dp2reg_done,
    output logic             err_unexpected_beat,
    output logic             err_layer_end
);
    localparam int TW = $clog2((PIPE_LAT > WARMUP ? PIPE_LAT : WARMUP) + 1);
    typedef enum logic [2:0] {IDLE, CFG, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic op_en_d1, done_d1, start, accept, last_beat;
    logic [TW-1:0] tcnt;
    logic [CNT_W-1:0] total;
    assign start       = reg2dp_op_en & (~op_en_d1 | done_d1);
    assign mac_in_rdy  = state == RUN;
    assign slcg_en     = state == CFG || state == RUN || state == DRAIN;
    assign op_busy     = state != IDLE;
    assign dp2reg_done = state == DONE;
    assign accept      = sc2mac_dat_valid & mac_in_rdy;
    assign last_beat   = accept & (beat_cnt == total);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CFG : IDLE;
            CFG:     state_nx = (tcnt == TW'(WARMUP - 1)) ? RUN : CFG;
            RUN:     state_nx = last_beat ? DRAIN : RUN;
            DRAIN:   state_nx = (tcnt == TW'(PIPE_LAT - 1)) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge nvdla_core_clk)
        state <= nvdla_core_rst ? IDLE : state_nx;
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            op_en_d1            <= 1'b0;
            done_d1             <= 1'b0;
            tcnt                <= '0;
            total               <= '0;
            beat_cnt            <= '0;
            cfg_is_int8         <= 1'b0;
            cfg_is_int16        <= 1'b1;
            cfg_is_fp16         <= 1'b0;
            cfg_is_wg           <= 1'b0;
            err_unexpected_beat <= 1'b0;
            err_layer_end       <= 1'b0;
        end else begin
            op_en_d1 <= reg2dp_op_en;
            done_d1  <= dp2reg_done;
            tcnt     <= (state_nx != state) ? '0 : tcnt + TW'(1);
            if (state == IDLE && start) begin
                cfg_is_int8         <= reg2dp_proc_precision == 2'd0;
                cfg_is_int16        <= reg2dp_proc_precision == 2'd1;
                cfg_is_fp16         <= reg2dp_proc_precision == 2'd2;
                cfg_is_wg           <= reg2dp_conv_mode;
                total               <= reg2dp_atomic_total;
                beat_cnt            <= '0;
                err_unexpected_beat <= 1'b0;
                err_layer_end       <= 1'b0;
            end
            // saturate so a full-range total ends on all-ones rather than wrapping
            if (accept)
                beat_cnt <= (&beat_cnt) ? beat_cnt : beat_cnt + CNT_W'(1);
            if (accept && ((beat_cnt == total) != sc2mac_dat_layer_end))
                err_layer_end <= 1'b1;
            if (sc2mac_dat_valid && state != RUN)
                err_unexpected_beat <= 1'b1;
        end
    end
endmodule

// File: tb/tb_nvdla_cmac_op_seq.sv
// tb_nvdla_cmac_op_seq: directed layer table, corner sequences and a random run against a timeline reference model.
module tb_nvdla_cmac_op_seq;
    localparam int W = 2, P = 7, CW = 24;
    localparam longint MAXC = (64'd1 << CW) - 1;
    logic clk = 0, rst = 1, op_en = 0, mode = 0, valid = 0, le = 0;
    logic [1:0] prec = 0;
    logic [CW-1:0] total = 0;
    logic mac_in_rdy, int8, int16, fp16, wg, slcg_en, op_busy, dp2reg_done, err_ub, err_le;
    logic [CW-1:0] beat_cnt;
    logic s_rdy, s_int8, s_int16, s_fp16, s_wg, s_slcg, s_busy, s_done, s_eub, s_ele;
    logic [2:0] s_cnt;
    int n_chk = 0, n_err = 0;

    nvdla_cmac_op_seq #(.CNT_W(CW), .PIPE_LAT(P), .WARMUP(W)) dut (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .reg2dp_op_en(op_en),
        .reg2dp_proc_precision(prec), .reg2dp_conv_mode(mode), .reg2dp_atomic_total(total),
        .sc2mac_dat_valid(valid), .sc2mac_dat_layer_end(le), .mac_in_rdy(mac_in_rdy),
        .cfg_is_int8(int8), .cfg_is_int16(int16), .cfg_is_fp16(fp16), .cfg_is_wg(wg),
        .slcg_en(slcg_en), .op_busy(op_busy), .beat_cnt(beat_cnt), .dp2reg_done(dp2reg_done),
        .err_unexpected_beat(err_ub), .err_layer_end(err_le));

    nvdla_cmac_op_seq #(.CNT_W(3), .PIPE_LAT(P), .WARMUP(W)) dut_s (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .reg2dp_op_en(op_en),
        .reg2dp_proc_precision(prec), .reg2dp_conv_mode(mode), .reg2dp_atomic_total(3'h7),
        .sc2mac_dat_valid(valid), .sc2mac_dat_layer_end(le), .mac_in_rdy(s_rdy),
        .cfg_is_int8(s_int8), .cfg_is_int16(s_int16), .cfg_is_fp16(s_fp16), .cfg_is_wg(s_wg),
        .slcg_en(s_slcg), .op_busy(s_busy), .beat_cnt(s_cnt), .dp2reg_done(s_done),
        .err_unexpected_beat(s_eub), .err_layer_end(s_ele));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a layer is a timeline (ready window opens WARMUP+1 after start,
    // done lands PIPE_LAT+1 after the last beat), not a state machine.
    bit m_ok = 0, m_busy, m_last, m_prev_op, m_prev_done, m_i8, m_i16, m_f16, m_wg, m_eub, m_ele;
    longint m_cnt, m_total, m_cyc = 0, m_rdy_from, m_done_at;

    function automatic void m_reset();
        m_busy = 0; m_last = 0; m_prev_op = 0; m_prev_done = 0;
        m_i8 = 0; m_i16 = 1; m_f16 = 0; m_wg = 0; m_eub = 0; m_ele = 0;
        m_cnt = 0; m_total = 0; m_rdy_from = 0; m_done_at = -1;
    endfunction

    always @(negedge clk) begin
        if (!m_ok) begin
            if (rst) begin
                m_reset();
                m_ok = 1;
            end
        end else begin
            bit e_rdy, e_done, st;
            m_cyc++;
            e_rdy  = m_busy && !m_last && m_cyc >= m_rdy_from;
            e_done = m_busy && m_cyc == m_done_at;
            chk("model rdy", mac_in_rdy, e_rdy);
            chk("model done", dp2reg_done, e_done);
            chk("model slcg", slcg_en, m_busy && !e_done);
            chk("model busy", op_busy, m_busy);
            chk("model beat_cnt", beat_cnt, m_cnt);
            chk("model int8", int8, m_i8);
            chk("model int16", int16, m_i16);
            chk("model fp16", fp16, m_f16);
            chk("model wg", wg, m_wg);
            chk("model err_ub", err_ub, m_eub);
            chk("model err_le", err_le, m_ele);
            if (rst) m_reset();
            else begin
                st = op_en && (!m_prev_op || m_prev_done);
                if (!m_busy && st) begin
                    m_i8 = prec == 0; m_i16 = prec == 1; m_f16 = prec == 2; m_wg = mode;
                    m_total = total; m_cnt = 0; m_eub = 0; m_ele = 0;
                    m_busy = 1; m_last = 0; m_rdy_from = m_cyc + W + 1; m_done_at = -1;
                end
                if (valid) begin
                    if (e_rdy) begin
                        if (m_cnt == m_total) begin
                            m_last = 1;
                            m_done_at = m_cyc + P + 1;
                            if (!le) m_ele = 1;
                        end else if (le) m_ele = 1;
                        if (m_cnt < MAXC) m_cnt++;
                    end else m_eub = 1;
                end
                if (e_done) m_busy = 0;
                m_prev_op = op_en;
                m_prev_done = e_done;
            end
        end
    end

    task automatic do_reset();
        rst = 1; op_en = 0; valid = 0; le = 0;
        tick(); tick();
        rst = 0;
    endtask

    // op_en pulses in cycle 0; beats are offered at every ready cycle; returns in the done cycle.
    task automatic run_layer(input logic [1:0] p, input logic m, input int tot, input int nb,
                             input int leb, input bit chg, output int f_rdy, output int d_cyc);
        int b = 0;
        f_rdy = -1; d_cyc = -1;
        op_en = 0; valid = 0; le = 0;
        tick();
        prec = p; mode = m; total = CW'(tot); op_en = 1;
        for (int t = 1; t <= 200 && d_cyc < 0; t++) begin
            tick();
            op_en = 0;
            if (chg && t == 4) prec = 2'd1;
            if (dp2reg_done) d_cyc = t;
            if (mac_in_rdy && f_rdy < 0) f_rdy = t;
            valid = mac_in_rdy && b < nb;
            le = valid && b == leb;
            if (valid) b++;
        end
        valid = 0; le = 0;
        chk("layer done seen", d_cyc >= 0, 1);
    endtask

    typedef struct {
        logic [1:0] p; logic m; int tot; int nb; int leb;
        int e_done; int e_cnt; logic [3:0] e_cfg; logic e_le;
    } vec_t;
    vec_t vt[5];

    initial begin
        int fr, dc, nd;
        int dcs[3];
        vt = '{
            '{2'd0, 1'b0, 3, 4, 3, 14, 4, 4'b1000, 1'b0},
            '{2'd2, 1'b1, 0, 1, 0, 11, 1, 4'b0011, 1'b0},
            '{2'd1, 1'b0, 3, 4, 1, 14, 4, 4'b0100, 1'b1},
            '{2'd3, 1'b1, 5, 6, 5, 16, 6, 4'b0001, 1'b0},
            '{2'd0, 1'b0, 2, 3, 9, 13, 3, 4'b1000, 1'b1}
        };
        do_reset();
        chk("reset busy", op_busy, 0);
        chk("reset int16", int16, 1);
        chk("reset int8", int8, 0);
        chk("reset done", dp2reg_done, 0);

        foreach (vt[i]) begin
            run_layer(vt[i].p, vt[i].m, vt[i].tot, vt[i].nb, vt[i].leb, 0, fr, dc);
            chk("tbl first rdy", fr, W + 1);
            chk("tbl done cycle", dc, vt[i].e_done);
            chk("tbl beat_cnt", beat_cnt, vt[i].e_cnt);
            chk("tbl cfg", {int8, int16, fp16, wg}, vt[i].e_cfg);
            chk("tbl err_le", err_le, vt[i].e_le);
            chk("tbl err_ub", err_ub, 0);
        end

        run_layer(2'd0, 1'b0, 3, 4, 3, 1, fr, dc);
        chk("prec change int8 held", int8, 1);
        chk("prec change int16 held", int16, 0);
        chk("prec change done", dc, 14);

        op_en = 0; valid = 0; tick();
        prec = 2'd2; mode = 1; total = 0; op_en = 1; nd = 0;
        for (int t = 1; t <= 100 && nd < 3; t++) begin
            tick();
            if (dp2reg_done) begin
                dcs[nd] = t;
                nd++;
            end
            valid = mac_in_rdy; le = mac_in_rdy;
        end
        op_en = 0; valid = 0; le = 0;
        chk("b2b layers", nd, 3);
        chk("b2b done0", dcs[0], 11);
        chk("b2b done1", dcs[1], 23);
        chk("b2b done2", dcs[2], 35);
        chk("b2b fp16", fp16, 1);
        chk("b2b wg", wg, 1);

        op_en = 0; tick();
        prec = 2'd0; mode = 0; total = 20; op_en = 1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            op_en = 0;
            valid = mac_in_rdy;
        end
        chk("pre-reset beats", beat_cnt, 4);
        rst = 1;
        tick();
        rst = 0; valid = 0;
        chk("mid reset busy", op_busy, 0);
        chk("mid reset rdy", mac_in_rdy, 0);
        chk("mid reset slcg", slcg_en, 0);
        chk("mid reset beat_cnt", beat_cnt, 0);
        chk("mid reset int16", int16, 1);
        chk("mid reset int8", int8, 0);
        run_layer(2'd0, 1'b0, 3, 4, 3, 0, fr, dc);
        chk("post reset done", dc, 14);

        do_reset();
        valid = 1; tick(); valid = 0;
        chk("idle beat err_ub", err_ub, 1);
        chk("idle beat cnt", beat_cnt, 0);
        prec = 0; total = 0; op_en = 1;
        tick(); valid = 1; op_en = 0;
        tick(); valid = 0;
        chk("cfg beat err_ub", err_ub, 1);
        chk("cfg beat cnt", beat_cnt, 0);
        for (int t = 0; t < 40 && !dp2reg_done; t++) begin
            tick();
            valid = mac_in_rdy; le = mac_in_rdy;
        end
        valid = 0; le = 0;
        chk("cfg beat layer done", dp2reg_done, 1);
        run_layer(2'd0, 1'b0, 0, 1, 0, 0, fr, dc);
        chk("err_ub cleared", err_ub, 0);

        do_reset();
        run_layer(2'd0, 1'b0, 7, 8, 7, 0, fr, dc);
        chk("sat done", dc, 18);
        chk("sat small done", s_done, 1);
        chk("sat small cnt", s_cnt, 7);
        chk("sat small err_le", s_ele, 0);
        chk("sat wide cnt", beat_cnt, 8);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(9) == 0) op_en = ~op_en;
            valid = $urandom_range(9) < 6;
            le = $urandom_range(3) == 0;
            prec = 2'($urandom_range(3));
            mode = 1'($urandom_range(1));
            total = CW'($urandom_range(6));
            rst = $urandom_range(299) == 0;
        end
        rst = 0; valid = 0;
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
